spi_cmd_master: RTL and testbench
=================================

Name: spi_cmd_master

Overview:
- Host-side SPI command master that sits directly upstream of the SPI slave/RAM wrapper.
- Converts parallel command requests into 10-bit serial frames:
  - frame = {data[7:0], op[1:0]}, transmitted bit 0 first, one bit per clk.
  - Drives ss_n and MOSI.
- For read-data commands, holds ss_n low after the frame and deserialises the returned MISO byte into a response.
- The slave and master share the system clk; there is no separate SCLK.

Parameters:
- ADDR_SIZE, 8: width of the frame data field and of the read response.
- RD_LATENCY, 2: turnaround cycles after a read-data frame before the first MISO sample (min 0).
- IDLE_GAP, 2: cycles ss_n is held high between frames (min 1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master can accept a command
- cmd_op  in  2  00 write address, 01 write data, 10 read address, 11 read data
- cmd_data  in  ADDR_SIZE  address/data field; ignored (sent as-is) for op 11
- rsp_valid  out  1  single-cycle pulse, read byte available
- rsp_data  out  ADDR_SIZE  received byte; held until the next response
- busy  out  1  high whenever not IDLE
- ss_n  out  1  slave select, active low
- MOSI  out  1  serial data to slave
- MISO  in  1  serial data from slave

Behaviour:
- Reset values (asynchronous):
  - ss_n=1, MOSI=0, rsp_valid=0, rsp_data=0, busy=0.
  - State=IDLE; cmd_ready=1 (combinational: high only in IDLE).
- States: IDLE, SHIFT, TURN, RECV, GAP.
- IDLE:
  - On cmd_valid && cmd_ready at edge T0: latch frame={cmd_data,cmd_op}, bit counter=0, go to SHIFT.
  - cmd_valid without cmd_ready is ignored; the host must hold the request.
- SHIFT (cycles T0+1..T0+10):
  - ss_n=0; MOSI=frame[cnt]; cnt increments each clk.
  - After cnt=9: if op==11 go to TURN (or straight to RECV if RD_LATENCY=0); otherwise go to GAP.
- TURN:
  - ss_n=0, MOSI=0 for RD_LATENCY cycles, then go to RECV.
- RECV:
  - ss_n=0, MOSI=0.
  - On each rising edge, shift MISO into rx register LSB-first: first sampled bit becomes rx[0].
  - After ADDR_SIZE samples, go to GAP.
- GAP:
  - ss_n=1, MOSI=0 for IDLE_GAP cycles, then go to IDLE.
  - If entered from RECV, rsp_data<=rx and rsp_valid=1 in the first GAP cycle only.
- Timing for op 11 with defaults:
  - ss_n low for exactly 10+RD_LATENCY+ADDR_SIZE = 20 cycles.
  - rsp_valid in cycle T0+21.
  - cmd_ready returns high at T0+23.
- Writes (op 00/01/10):
  - ss_n low for 10 cycles.
  - No rsp_valid.
  - Next command accepted IDLE_GAP cycles after ss_n rises.
- There is no response backpressure; rsp_valid is a pulse the consumer must capture.
- Boundary conditions:
  - Reset mid-frame: ss_n rises immediately (async), the frame is aborted, no rsp_valid, rsp_data is cleared.
  - A command arriving during GAP waits; it is never dropped while the host holds cmd_valid.
  - cmd_data and cmd_op changing after acceptance have no effect on the frame in flight.
  - Bit counter is sized to hold max(10, ADDR_SIZE, RD_LATENCY); no wrap inside a phase.

Optional Feature:
- Macro: SPI_CMD_MASTER_AUTO_READ_EN
- Defined:
  - An accepted op 10 (read address) frame is followed automatically, after the normal GAP, by an internally generated op 11 frame with data field 0.
  - This proceeds through TURN/RECV and produces rsp_valid.
  - cmd_ready and busy stay low/high across both frames.
  - A reset during either frame aborts both.
- Undefined:
  - op 10 sends only its own frame; the host must issue op 11 explicitly.

Test Plan:
- Reset, then op=00 data=0x05:
  - MOSI bits over T0+1..T0+10 = 0,0,1,0,1,0,0,0,0,0.
  - ss_n low exactly 10 cycles, no rsp_valid.
  - cmd_ready back high 2 cycles after ss_n rises.
- op=01 data=0xAA:
  - MOSI sequence 1,0,0,1,0,1,0,1,0,1.
  - No rsp_valid.
- op=11, with slave model driving MISO 0,1,0,1,0,1,0,1 in RECV:
  - ss_n low 20 cycles.
  - rsp_valid single pulse at T0+21 with rsp_data=0xAA.
- Back-to-back cmd_valid held high with two writes:
  - Second frame's ss_n falls exactly IDLE_GAP+1 cycles after the first frame's ss_n rises.
  - No bits lost or duplicated.
- reset_n pulsed low during SHIFT cnt=4 of an op 11:
  - ss_n=1 and MOSI=0 immediately.
  - No rsp_valid.
  - cmd_ready=1 after release; the next op 00 frame is correct.
- With SPI_CMD_MASTER_AUTO_READ_EN, op=10 data=0x05 and slave returning 0x3C:
  - Two frames: 10 ss_n-low cycles, then 2-cycle gap, then 20 ss_n-low cycles.
  - Single rsp_valid with rsp_data=0x3C; cmd_ready low throughout.

Source files
------------

// File: rtl/spi_cmd_master.sv
// SPI command master: serialises {data, op} frames LSB-first on MOSI and deserialises read bytes from MISO.
// Optional macro SPI_CMD_MASTER_AUTO_READ_EN chains an internal read-data frame after each read-address frame.
module spi_cmd_master #(
   parameter int ADDR_SIZE  = 8,
   parameter int RD_LATENCY = 2,
   parameter int IDLE_GAP   = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [ADDR_SIZE-1:0] cmd_data,
   output logic                 rsp_valid,
   output logic [ADDR_SIZE-1:0] rsp_data,
   output logic                 busy,
   output logic                 ss_n,
   output logic                 MOSI,
   input  logic                 MISO
);
   localparam int FRAME_W = ADDR_SIZE + 2;
   localparam int CNT_M0  = (FRAME_W > RD_LATENCY) ? FRAME_W : RD_LATENCY;
   localparam int CNT_MAX = (CNT_M0 > IDLE_GAP) ? CNT_M0 : IDLE_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_TURN,
      ST_RECV,
      ST_GAP
   } state_t;

   state_t               r_state, w_state_next;
   logic [CNT_W-1:0]     r_cnt, w_cnt_next;
   logic [FRAME_W-1:0]   r_frame, w_frame_next;
   logic [ADDR_SIZE-1:0] r_rx, w_rx_next;
   logic                 r_rsp_valid, w_rsp_valid_next;
   logic [ADDR_SIZE-1:0] r_rsp_data, w_rsp_data_next;
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
   logic                 r_auto, w_auto_next;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_frame     <= '0;
         r_rx        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
         r_auto      <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_frame     <= w_frame_next;
         r_rx        <= w_rx_next;
         r_rsp_valid <= w_rsp_valid_next;
         r_rsp_data  <= w_rsp_data_next;
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
         r_auto      <= w_auto_next;
`endif
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_frame_next     = r_frame;
      w_rx_next        = r_rx;
      w_rsp_valid_next = 1'b0;
      w_rsp_data_next  = r_rsp_data;
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
      w_auto_next      = r_auto;
`endif
      cmd_ready        = 1'b0;
      busy             = 1'b1;
      ss_n             = 1'b1;
      MOSI             = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               w_frame_next = {cmd_data, cmd_op};
               w_cnt_next   = '0;
               w_state_next = ST_SHIFT;
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
               w_auto_next  = (cmd_op == 2'b10);
`endif
            end
         end
         ST_SHIFT: begin
            ss_n = 1'b0;
            MOSI = r_frame[r_cnt];
            if (r_cnt == CNT_W'(FRAME_W - 1)) begin
               w_cnt_next = '0;
               if (r_frame[1:0] == 2'b11)
                  w_state_next = (RD_LATENCY == 0) ? ST_RECV : ST_TURN;
               else
                  w_state_next = ST_GAP;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_TURN: begin
            ss_n = 1'b0;
            if (r_cnt == CNT_W'(RD_LATENCY - 1)) begin
               w_cnt_next   = '0;
               w_state_next = ST_RECV;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_RECV: begin
            ss_n      = 1'b0;
            w_rx_next = {MISO, r_rx[ADDR_SIZE-1:1]};
            // The last sample goes straight into the response so it is valid in the first GAP cycle
            if (r_cnt == CNT_W'(ADDR_SIZE - 1)) begin
               w_cnt_next       = '0;
               w_state_next     = ST_GAP;
               w_rsp_valid_next = 1'b1;
               w_rsp_data_next  = w_rx_next;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_GAP: begin
            if (r_cnt == CNT_W'(IDLE_GAP - 1)) begin
               w_cnt_next   = '0;
               w_state_next = ST_IDLE;
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
               if (r_auto) begin
                  w_auto_next  = 1'b0;
                  w_frame_next = {{ADDR_SIZE{1'b0}}, 2'b11};
                  w_state_next = ST_SHIFT;
               end
`endif
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: a cycle-level frame model builds expected ss_n/MOSI/ready/response traces.
// Honours SPI_CMD_MASTER_AUTO_READ_EN so op 10 is modelled as two frames when the feature is built in.
`timescale 1ns/1ps
module tb_spi_cmd_master;
   localparam int AW   = 8;
   localparam int RL   = 2;
   localparam int IG   = 2;
   localparam int MAXN = 160;

   logic          clk       = 1'b0;
   logic          reset_n   = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_op    = '0;
   logic [AW-1:0] cmd_data  = '0;
   logic          MISO      = 1'b0;
   logic          cmd_ready, rsp_valid, busy, ss_n, MOSI;
   logic [AW-1:0] rsp_data;

   spi_cmd_master #(.ADDR_SIZE(AW), .RD_LATENCY(RL), .IDLE_GAP(IG)) dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .busy(busy), .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected trace, one bit per cycle; cycle 0 is the cycle in which the first command is accepted
   int              exp_len;
   logic [MAXN-1:0] exp_ss, exp_mosi, exp_rv, exp_rdy, exp_busy, exp_win, exp_miso;
   logic [MAXN-1:0] obs_ss, obs_mosi, obs_rv, obs_rdy, obs_busy;
   logic [AW-1:0]   model_rsp = '0;
   logic [AW-1:0]   exp_rsp_q[$];
   logic [AW-1:0]   obs_rsp_q[$];
   logic [AW-1:0]   obs_final_rd;
   logic [1:0]      q_op[$];
   logic [AW-1:0]   q_data[$];

   task automatic new_seq();
      exp_len = 0;
      exp_ss = '0; exp_mosi = '0; exp_rv = '0; exp_rdy = '0; exp_busy = '0; exp_win = '0; exp_miso = '0;
      obs_ss = '0; obs_mosi = '0; obs_rv = '0; obs_rdy = '0; obs_busy = '0;
      exp_rsp_q.delete(); obs_rsp_q.delete(); q_op.delete(); q_data.delete();
   endtask

   task automatic push_cycle(input logic ss, input logic mosi, input logic rv, input logic rdy,
                             input logic win, input logic mbit);
      exp_ss[exp_len]   = ss;
      exp_mosi[exp_len] = mosi;
      exp_rv[exp_len]   = rv;
      exp_rdy[exp_len]  = rdy;
      exp_busy[exp_len] = ~rdy;
      exp_win[exp_len]  = win;
      exp_miso[exp_len] = mbit;
      exp_len++;
   endtask

   // One frame: optional accept cycle, 10 frame bits, turnaround + receive for reads, then the high gap
   task automatic add_frame(input logic from_host, input logic [1:0] op, input logic [AW-1:0] data,
                            input logic [AW-1:0] rx);
      logic [AW+1:0] fr;
      fr = {data, op};
      if (from_host) begin
         push_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         q_op.push_back(op);
         q_data.push_back(data);
      end
      for (int i = 0; i < AW + 2; i++) push_cycle(1'b0, fr[i], 1'b0, 1'b0, 1'b0, 1'b0);
      if (op == 2'b11) begin
         for (int i = 0; i < RL; i++) push_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         for (int i = 0; i < AW; i++) push_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rx[i]);
         exp_rsp_q.push_back(rx);
         model_rsp = rx;
      end
      for (int i = 0; i < IG; i++) push_cycle(1'b1, 1'b0, (i == 0) && (op == 2'b11), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic add_cmd(input logic [1:0] op, input logic [AW-1:0] data, input logic [AW-1:0] rx);
      add_frame(1'b1, op, data, rx);
`ifdef SPI_CMD_MASTER_AUTO_READ_EN
      if (op == 2'b10) add_frame(1'b0, 2'b11, '0, rx);
`endif
   endtask

   task automatic end_seq();
      push_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // Host holds each queued command until it sees cmd_ready; slave drives MISO only in the read window
   task automatic run_seq(input int stop_at);
      for (int k = 0; k < exp_len; k++) begin
         @(negedge clk);
         if (q_op.size() > 0) begin
            cmd_valid = 1'b1;
            cmd_op    = q_op[0];
            cmd_data  = q_data[0];
            if (cmd_ready === 1'b1) begin
               void'(q_op.pop_front());
               void'(q_data.pop_front());
            end
         end else begin
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom);
            cmd_data  = AW'($urandom);
         end
         MISO = exp_win[k] ? exp_miso[k] : 1'($urandom);
         #1;
         obs_ss[k]   = ss_n;
         obs_mosi[k] = MOSI;
         obs_rv[k]   = rsp_valid;
         obs_rdy[k]  = cmd_ready;
         obs_busy[k] = busy;
         if (rsp_valid === 1'b1) obs_rsp_q.push_back(rsp_data);
         obs_final_rd = rsp_data;
         if (k == stop_at) break;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #1;
      n_checks++; if (ss_n !== 1'b1) begin n_fail++; $display("FAIL reset ss_n got %b exp 1", ss_n); end
      n_checks++; if (MOSI !== 1'b0) begin n_fail++; $display("FAIL reset MOSI got %b exp 0", MOSI); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid got %b exp 0", rsp_valid); end
      n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset rsp_data got %h exp 00", rsp_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", busy); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready got %b exp 1", cmd_ready); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_checks++; if (cmd_ready !== 1'b1 || ss_n !== 1'b1) begin
         n_fail++; $display("FAIL reset_release ready/ss_n got %b%b exp 11", cmd_ready, ss_n);
      end
      $display("txn reset: done");
   endtask

   task automatic test_writes();
      logic [1:0]    ops[2]   = '{2'b00, 2'b01};
      logic [AW-1:0] datas[2] = '{8'h05, 8'hAA};
      for (int t = 0; t < 2; t++) begin
         new_seq(); add_cmd(ops[t], datas[t], '0); end_seq(); run_seq(-1);
         n_checks++; if (obs_ss !== exp_ss) begin n_fail++; $display("FAIL write%0d ss_n got %h exp %h", t, obs_ss, exp_ss); end
         n_checks++; if (obs_mosi !== exp_mosi) begin n_fail++; $display("FAIL write%0d MOSI got %h exp %h", t, obs_mosi, exp_mosi); end
         n_checks++; if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL write%0d rsp_valid got %h exp %h", t, obs_rv, exp_rv); end
         n_checks++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL write%0d cmd_ready got %h exp %h", t, obs_rdy, exp_rdy); end
         n_checks++; if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL write%0d busy got %h exp %h", t, obs_busy, exp_busy); end
         $display("txn write op=%b data=%h cycles=%0d", ops[t], datas[t], exp_len);
      end
   endtask

   task automatic test_read();
      new_seq(); add_cmd(2'b11, 8'h96, 8'hAA); end_seq(); run_seq(-1);
      n_checks++; if (obs_ss !== exp_ss) begin n_fail++; $display("FAIL read ss_n got %h exp %h", obs_ss, exp_ss); end
      n_checks++; if (obs_mosi !== exp_mosi) begin n_fail++; $display("FAIL read MOSI got %h exp %h", obs_mosi, exp_mosi); end
      n_checks++; if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL read rsp_valid got %h exp %h", obs_rv, exp_rv); end
      n_checks++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL read cmd_ready got %h exp %h", obs_rdy, exp_rdy); end
      n_checks++; if (obs_final_rd !== 8'hAA) begin n_fail++; $display("FAIL read rsp_data got %h exp aa", obs_final_rd); end
      $display("txn read op=11 rsp=%h cycles=%0d", obs_final_rd, exp_len);
   endtask

   task automatic test_back_to_back();
      new_seq(); add_cmd(2'b00, 8'h3C, '0); add_cmd(2'b01, 8'hC5, '0); end_seq(); run_seq(-1);
      n_checks++; if (obs_ss !== exp_ss) begin n_fail++; $display("FAIL b2b ss_n got %h exp %h", obs_ss, exp_ss); end
      n_checks++; if (obs_mosi !== exp_mosi) begin n_fail++; $display("FAIL b2b MOSI got %h exp %h", obs_mosi, exp_mosi); end
      n_checks++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL b2b cmd_ready got %h exp %h", obs_rdy, exp_rdy); end
      n_checks++; if (obs_rv !== '0) begin n_fail++; $display("FAIL b2b rsp_valid got %h exp 0", obs_rv); end
      $display("txn back_to_back cmds=2 cycles=%0d", exp_len);
   endtask

   task automatic test_reset_mid_frame();
      logic [MAXN-1:0] mask;
      int              pulses;
      mask = (MAXN'(1) << 6) - MAXN'(1);
      new_seq(); add_cmd(2'b11, AW'($urandom), AW'($urandom)); end_seq(); run_seq(5);
      n_checks++; if ((obs_ss & mask) !== (exp_ss & mask)) begin n_fail++; $display("FAIL rst_mid pre ss_n got %h exp %h", obs_ss & mask, exp_ss & mask); end
      n_checks++; if ((obs_mosi & mask) !== (exp_mosi & mask)) begin n_fail++; $display("FAIL rst_mid pre MOSI got %h exp %h", obs_mosi & mask, exp_mosi & mask); end
      #1 reset_n = 1'b0;
      #1;
      model_rsp = '0;
      n_checks++; if (ss_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid ss_n got %b exp 1", ss_n); end
      n_checks++; if (MOSI !== 1'b0) begin n_fail++; $display("FAIL rst_mid MOSI got %b exp 0", MOSI); end
      n_checks++; if (rsp_data !== model_rsp) begin n_fail++; $display("FAIL rst_mid rsp_data got %h exp %h", rsp_data, model_rsp); end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid cmd_ready got %b exp 1", cmd_ready); end
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) pulses++;
      end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_mid rsp_valid pulses got %0d exp 0", pulses); end
      new_seq(); add_cmd(2'b00, 8'h5A, '0); end_seq(); run_seq(-1);
      n_checks++; if (obs_ss !== exp_ss) begin n_fail++; $display("FAIL rst_mid next ss_n got %h exp %h", obs_ss, exp_ss); end
      n_checks++; if (obs_mosi !== exp_mosi) begin n_fail++; $display("FAIL rst_mid next MOSI got %h exp %h", obs_mosi, exp_mosi); end
      $display("txn reset_mid_frame pulses=%0d", pulses);
   endtask

   task automatic test_auto_read();
      new_seq(); add_cmd(2'b10, 8'h05, 8'h3C); end_seq(); run_seq(-1);
      n_checks++; if (obs_ss !== exp_ss) begin n_fail++; $display("FAIL auto ss_n got %h exp %h", obs_ss, exp_ss); end
      n_checks++; if (obs_mosi !== exp_mosi) begin n_fail++; $display("FAIL auto MOSI got %h exp %h", obs_mosi, exp_mosi); end
      n_checks++; if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL auto rsp_valid got %h exp %h", obs_rv, exp_rv); end
      n_checks++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL auto cmd_ready got %h exp %h", obs_rdy, exp_rdy); end
      n_checks++; if (obs_final_rd !== model_rsp) begin n_fail++; $display("FAIL auto rsp_data got %h exp %h", obs_final_rd, model_rsp); end
      $display("txn auto_read op=10 cycles=%0d rsp=%h", exp_len, obs_final_rd);
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 8; r++) begin
         new_seq();
         n = $urandom_range(1, 3);
         for (int c = 0; c < n; c++) add_cmd(2'($urandom), AW'($urandom), AW'($urandom));
         end_seq(); run_seq(-1);
         n_checks++; if (obs_ss !== exp_ss) begin n_fail++; $display("FAIL rand%0d ss_n got %h exp %h", r, obs_ss, exp_ss); end
         n_checks++; if (obs_mosi !== exp_mosi) begin n_fail++; $display("FAIL rand%0d MOSI got %h exp %h", r, obs_mosi, exp_mosi); end
         n_checks++; if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL rand%0d rsp_valid got %h exp %h", r, obs_rv, exp_rv); end
         n_checks++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand%0d cmd_ready got %h exp %h", r, obs_rdy, exp_rdy); end
         n_checks++; if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL rand%0d busy got %h exp %h", r, obs_busy, exp_busy); end
         n_checks++; if (obs_rsp_q.size() != exp_rsp_q.size()) begin
            n_fail++; $display("FAIL rand%0d rsp_count got %0d exp %0d", r, obs_rsp_q.size(), exp_rsp_q.size());
         end else begin
            foreach (exp_rsp_q[i]) begin
               n_checks++;
               if (obs_rsp_q[i] !== exp_rsp_q[i]) begin
                  n_fail++; $display("FAIL rand%0d rsp_data[%0d] got %h exp %h", r, i, obs_rsp_q[i], exp_rsp_q[i]);
               end
            end
         end
         n_checks++; if (obs_final_rd !== model_rsp) begin n_fail++; $display("FAIL rand%0d held rsp_data got %h exp %h", r, obs_final_rd, model_rsp); end
         $display("txn random%0d cmds=%0d cycles=%0d rsps=%0d", r, n, exp_len, obs_rsp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_writes();
      test_read();
      test_back_to_back();
      test_reset_mid_frame();
      test_auto_read();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
